sys_peripheral_hub: RTL and testbench
=====================================

SYS_PERIPHERAL_HUB -- requirements
Module: sys_peripheral_hub

Interface
REQ-001 Parameter SP_NUM, default 8, number of attached system peripherals (1..8, indexed by the 3-bit ID field).
REQ-002 Parameter TIMEOUT_CYCLES, default 15, maximum number of WAIT cycles before an error response (1..255).
REQ-003 clk  in  1  the single block clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 req  in  1  host request; sampled only in IDLE.
REQ-006 we  in  1  host write enable (1 = write, 0 = read).
REQ-007 addr  in  5  host address: [4:2] is the peripheral ID, [1:0] is the register offset.
REQ-008 wdata  in  32  host write data.
REQ-009 ready  out  1  one-cycle pulse marking transaction completion.
REQ-010 rdata  out  32  read data, valid when ready=1.
REQ-011 err  out  1  error flag, valid when ready=1.
REQ-012 sys  out  sys_peripheral_t  shared raddr/waddr/wdata bundle fanned out to all peripherals.
REQ-013 rd_sel  out  SP_NUM  one-hot read select.
REQ-014 wr_sel  out  SP_NUM  one-hot write select.
REQ-015 sp_rdata  in  SP_NUM*32  peripheral read data; peripheral i occupies bits [32i+31:32i].
REQ-016 sp_ack  in  SP_NUM  peripheral completion acknowledge.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS, WAIT and RESP.
REQ-018 In IDLE with req=1, the block SHALL capture addr, we and wdata and go to ACCESS on the next edge.
REQ-019 The block SHALL drive sys.raddr and sys.waddr with the captured addr[1:0] and sys.wdata with the captured wdata, and SHALL hold these values until the next acceptance.
REQ-020 ID < SP_NUM: during ACCESS and WAIT, the block SHALL assert bit ID of rd_sel (read) or wr_sel (write); all other select bits SHALL be 0.
REQ-021 ID >= SP_NUM: the block SHALL assert no select, go from ACCESS directly to RESP, and set err=1 and rdata=0.
REQ-022 ACCESS or WAIT with sp_ack[ID]=1: the block SHALL latch sp_rdata slice ID into rdata (reads only; writes SHALL yield rdata=0) and go to RESP.
REQ-023 ACCESS or WAIT with sp_ack[ID]=0: the block SHALL go to, or stay in, WAIT.
REQ-024 sp_ack bits of non-selected peripherals SHALL be ignored.
REQ-025 RESP SHALL last exactly one cycle with ready=1, then return to IDLE; req is not accepted in that cycle.
REQ-026 Minimum latency SHALL be 2 cycles from the req sample to the ready pulse (IDLE, ACCESS with ack, RESP).
REQ-027 err SHALL be 0 and rdata SHALL be 0 whenever ready=0.
REQ-028 req asserted outside IDLE SHALL be ignored; host inputs are not required to be held after acceptance.

Reset
REQ-029 While rst=1, the block SHALL be in IDLE with ready=0, err=0, rdata=0, rd_sel=0, wr_sel=0, sys fields all 0 and the timeout counter at 0.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately with no ready pulse.
REQ-031 A req present on the first edge after rst deasserts SHALL be accepted.

Configuration
REQ-032 With SP_HUB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to ACCESS and increment each WAIT cycle; on reaching TIMEOUT_CYCLES without sp_ack[ID], the block SHALL go to RESP with err=1 and rdata=0, deasserting selects.
REQ-033 An sp_ack[ID] arriving on the same cycle the count reaches TIMEOUT_CYCLES SHALL take precedence (normal completion, err=0).
REQ-034 Without SP_HUB_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL persist until sp_ack[ID]=1.

Verification
REQ-035 Read addr=5'b010_01 with sp_ack[2] tied high and sp_rdata[2]=32'hDEADBEEF -> rd_sel=8'h04 for one cycle, sys.raddr=2'b01, ready 2 cycles after req with rdata=32'hDEADBEEF and err=0.
REQ-036 Write addr=5'b111_10, wdata=32'h12345678, sp_ack[7] delayed 3 cycles -> wr_sel=8'h80 held for 4 cycles, sys.waddr=2'b10, sys.wdata=32'h12345678, ready with err=0 and rdata=0.
REQ-037 SP_NUM=4, read addr=5'b101_00 -> no select asserted, ready 2 cycles after req with err=1 and rdata=0.
REQ-038 With SP_HUB_TIMEOUT_EN and TIMEOUT_CYCLES=15, read ID 3 with sp_ack never asserted -> ready with err=1 after 15 WAIT cycles; repeat with ack at the 15th WAIT cycle -> err=0.
REQ-039 rst pulsed during WAIT of a read -> all outputs 0 asynchronously, no ready pulse; a req on the first edge after release is accepted.
REQ-040 Back-to-back req held high with sp_ack tied high -> one transaction every 3 cycles; sp_ack on non-selected bits causes no completion.

Source files
------------

// File: rtl/sys_peripheral_hub.sv
// Host-to-system-peripheral bridge: one-hot select fan-out, ack/timeout handling, one-cycle response.
// Optional WAIT timeout is enabled by defining SP_HUB_TIMEOUT_EN.
package sys_peripheral_hub_pkg;
    typedef struct packed {
        logic [1:0]  raddr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
    } sys_peripheral_t;
endpackage

module sys_peripheral_hub
    import sys_peripheral_hub_pkg::*;
#(
    parameter int SP_NUM         = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdata,
    output logic                 ready,
    output logic [31:0]          rdata,
    output logic                 err,
    output sys_peripheral_t      sys,
    output logic [SP_NUM-1:0]    rd_sel,
    output logic [SP_NUM-1:0]    wr_sel,
    input  logic [SP_NUM*32-1:0] sp_rdata,
    input  logic [SP_NUM-1:0]    sp_ack
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    if (SP_NUM < 1 || SP_NUM > 8) begin : g_bad_sp_num
        $error("SP_NUM must be in 1..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    // IDs at or above SP_NUM decode to all-zero, which doubles as the invalid-ID flag.
    function automatic logic [SP_NUM-1:0] id_onehot_f(input logic [2:0] id);
        logic [SP_NUM-1:0] oh;
        oh = {SP_NUM{1'b0}};
        for (int i = 0; i < SP_NUM; i++) begin
            oh[i] = (id == 3'(i));
        end
        return oh;
    endfunction

    state_t            state_q, state_d;
    logic [4:0]        addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [SP_NUM-1:0] rd_sel_q, rd_sel_d;
    logic [SP_NUM-1:0] wr_sel_q, wr_sel_d;
    logic [SP_NUM-1:0] id_oh_s;
    logic              id_valid_s;
    logic              ack_hit_s;
    logic              timeout_s;
    logic [31:0]       sel_rdata_s;

    // Decode the captured ID and pick out its ack bit and read-data slice.
    always_comb begin
        id_oh_s     = id_onehot_f(addr_q[4:2]);
        id_valid_s  = |id_oh_s;
        ack_hit_s   = |(sp_ack & id_oh_s);
        sel_rdata_s = 32'd0;
        for (int i = 0; i < SP_NUM; i++) begin
            sel_rdata_s = sel_rdata_s | (sp_rdata[32*i +: 32] & {32{id_oh_s[i]}});
        end
    end

`ifdef SP_HUB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // WAIT cycle counter, cleared when a request is accepted.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && req) begin
            cnt_d = 8'd0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign timeout_s = (state_q == WAIT) && (cnt_d == TIMEOUT_CYCLES[7:0]);

    // Timeout counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and registered-output logic; ack wins over a same-cycle timeout.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = 32'd0;
        err_d    = 1'b0;
        rd_sel_d = {SP_NUM{1'b0}};
        wr_sel_d = {SP_NUM{1'b0}};
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS, WAIT: begin
                if (!id_valid_s) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (ack_hit_s) begin
                    state_d = RESP;
                    rdata_d = we_q ? 32'd0 : sel_rdata_s;
                end else if (timeout_s) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == RESP);
        if (state_d == ACCESS || state_d == WAIT) begin
            rd_sel_d = we_d ? {SP_NUM{1'b0}} : id_onehot_f(addr_d[4:2]);
            wr_sel_d = we_d ? id_onehot_f(addr_d[4:2]) : {SP_NUM{1'b0}};
        end else begin
            rd_sel_d = {SP_NUM{1'b0}};
            wr_sel_d = {SP_NUM{1'b0}};
        end
    end

    // State, captured request and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= 5'd0;
            we_q     <= 1'b0;
            wdata_q  <= 32'd0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            rd_sel_q <= {SP_NUM{1'b0}};
            wr_sel_q <= {SP_NUM{1'b0}};
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rd_sel_q <= rd_sel_d;
            wr_sel_q <= wr_sel_d;
        end
    end

    assign ready  = ready_q;
    assign err    = err_q;
    assign rdata  = rdata_q;
    assign rd_sel = rd_sel_q;
    assign wr_sel = wr_sel_q;
    assign sys    = {addr_q[1:0], addr_q[1:0], wdata_q};

endmodule

// File: tb/tb_sys_peripheral_hub.sv
// Directed bench for sys_peripheral_hub: vector table plus reset, invalid-ID, back-to-back and WAIT/timeout sequences.
module tb_sys_peripheral_hub;
    import sys_peripheral_hub_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            req;
    logic            we;
    logic [4:0]      addr;
    logic [31:0]     wdata;
    logic            ready, err, ready4, err4;
    logic [31:0]     rdata, rdata4;
    sys_peripheral_t sys, sys4;
    logic [7:0]      rd_sel, wr_sel, sp_ack;
    logic [3:0]      rd_sel4, wr_sel4;
    logic [255:0]    sp_rdata;
    logic [127:0]    sp_rdata4;
    logic [3:0]      sp_ack4;

    int n_checks = 0;
    int n_errors = 0;

    int          obs_lat, obs_sel_cyc, obs_bad;
    logic [7:0]  obs_rd_or, obs_wr_or, obs_sel_rdy;
    logic [31:0] obs_rdata;
    logic        obs_err;
    sys_peripheral_t obs_sys;

    always #5 clk = ~clk;

    sys_peripheral_hub #(.SP_NUM(8), .TIMEOUT_CYCLES(15)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .err(err), .sys(sys),
        .rd_sel(rd_sel), .wr_sel(wr_sel), .sp_rdata(sp_rdata), .sp_ack(sp_ack)
    );

    sys_peripheral_hub #(.SP_NUM(4), .TIMEOUT_CYCLES(15)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready4), .rdata(rdata4), .err(err4), .sys(sys4),
        .rd_sel(rd_sel4), .wr_sel(wr_sel4), .sp_rdata(sp_rdata4), .sp_ack(sp_ack4)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          delay;
        logic        noise;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_wr;
        int          exp_lat;
        int          exp_sel_cyc;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request; ack the selected peripheral 'delay' cycles after ACCESS (k=0).
    task automatic do_txn(input logic w, input logic [4:0] a, input logic [31:0] d,
                          input int delay, input logic noise);
        logic [7:0] oh;
        oh = 8'd1 << a[4:2];
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; sp_ack = 8'd0;
        obs_lat = -1; obs_sel_cyc = 0; obs_bad = 0;
        obs_rd_or = 8'd0; obs_wr_or = 8'd0; obs_sel_rdy = 8'hEE;
        obs_rdata = 32'hEEEEEEEE; obs_err = 1'b1; obs_sys = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
            if (ready) begin
                obs_lat = k; obs_rdata = rdata; obs_err = err;
                obs_sel_rdy = rd_sel | wr_sel; obs_sys = sys;
                break;
            end
            if (err || rdata != 32'd0) obs_bad++;
            obs_rd_or = obs_rd_or | rd_sel;
            obs_wr_or = obs_wr_or | wr_sel;
            if ((rd_sel | wr_sel) != 8'd0) obs_sel_cyc++;
            if (k >= delay) sp_ack = oh;
            else if (noise) sp_ack = ~oh;
            else sp_ack = 8'd0;
        end
        sp_ack = 8'd0;
    endtask

    task automatic chk_txn(input string nm, input logic [4:0] a, input logic [31:0] d,
                           input int lat, input int sel_cyc, input logic [7:0] rd_or,
                           input logic [7:0] wr_or, input logic [31:0] rdat, input logic e);
        chk({nm, "_latency"}, obs_lat, lat);
        chk({nm, "_sel_cycles"}, obs_sel_cyc, sel_cyc);
        chk({nm, "_rd_sel"}, {24'd0, obs_rd_or}, {24'd0, rd_or});
        chk({nm, "_wr_sel"}, {24'd0, obs_wr_or}, {24'd0, wr_or});
        chk({nm, "_rdata"}, obs_rdata, rdat);
        chk({nm, "_err"}, {31'd0, obs_err}, {31'd0, e});
        chk({nm, "_sel_at_ready"}, {24'd0, obs_sel_rdy}, 32'd0);
        chk({nm, "_idle_outputs"}, obs_bad, 32'd0);
        chk({nm, "_raddr"}, {30'd0, obs_sys.raddr}, {30'd0, a[1:0]});
        chk({nm, "_waddr"}, {30'd0, obs_sys.waddr}, {30'd0, a[1:0]});
        chk({nm, "_wdata"}, obs_sys.wdata, d);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        int rdy_seen;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
        sp_ack = 8'd0; sp_ack4 = 4'hF;
        for (int i = 0; i < 8; i++) sp_rdata[32*i +: 32] = {16'hC0DE, 16'(i)};
        sp_rdata[95:64] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) sp_rdata4[32*i +: 32] = {16'hBEE0, 16'(i)};

        vecs[0] = '{1'b0, 5'b010_01, 32'h0BADF00D, 0, 1'b0, 8'h04, 8'h00, 1, 1, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 5'b111_10, 32'h12345678, 3, 1'b0, 8'h00, 8'h80, 4, 4, 32'h00000000, 1'b0};
        vecs[2] = '{1'b0, 5'b000_11, 32'h00000000, 2, 1'b1, 8'h01, 8'h00, 3, 3, 32'hC0DE0000, 1'b0};
        vecs[3] = '{1'b0, 5'b101_00, 32'h11112222, 1, 1'b0, 8'h20, 8'h00, 2, 2, 32'hC0DE0005, 1'b0};
        vecs[4] = '{1'b1, 5'b011_01, 32'hA5A5A5A5, 1, 1'b1, 8'h00, 8'h08, 2, 2, 32'h00000000, 1'b0};

        // Reset state.
        @(negedge clk); @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_sel", {16'd0, rd_sel, wr_sel}, 32'd0);
        chk("reset_sys", {28'd0, sys.raddr, sys.waddr}, 32'd0);
        chk("reset_sys_wdata", sys.wdata, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            do_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].delay, vecs[v].noise);
            chk_txn($sformatf("vec%0d", v), vecs[v].addr, vecs[v].wdata, vecs[v].exp_lat,
                    vecs[v].exp_sel_cyc, vecs[v].exp_rd, vecs[v].exp_wr, vecs[v].exp_rdata,
                    vecs[v].exp_err);
        end

`ifdef SP_HUB_TIMEOUT_EN
        do_txn(1'b0, 5'b011_00, 32'd0, 1000, 1'b0);
        chk_txn("timeout_noack", 5'b011_00, 32'd0, 16, 16, 8'h08, 8'h00, 32'd0, 1'b1);
        do_txn(1'b0, 5'b011_00, 32'd0, 15, 1'b0);
        chk_txn("timeout_ack_last", 5'b011_00, 32'd0, 16, 16, 8'h08, 8'h00, 32'hC0DE0003, 1'b0);
`else
        do_txn(1'b0, 5'b011_00, 32'd0, 40, 1'b0);
        chk_txn("long_wait", 5'b011_00, 32'd0, 41, 41, 8'h08, 8'h00, 32'hC0DE0003, 1'b0);
`endif

        // Invalid ID on a 4-peripheral hub.
        pulse_reset();
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 5'b101_00;
        @(negedge clk); req = 1'b0;
        chk("inv_sel", {24'd0, rd_sel4, wr_sel4}, 32'd0);
        chk("inv_ready_early", {31'd0, ready4}, 32'd0);
        @(negedge clk);
        chk("inv_ready", {31'd0, ready4}, 32'd1);
        chk("inv_err", {31'd0, err4}, 32'd1);
        chk("inv_rdata", rdata4, 32'd0);
        @(negedge clk);
        chk("inv_ready_pulse", {31'd0, ready4}, 32'd0);
        chk("inv_err_cleared", {31'd0, err4}, 32'd0);

        // Reset during WAIT, then a request on the first edge after release.
        pulse_reset();
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 5'b011_00; wdata = 32'h55AA55AA;
        @(negedge clk); req = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("abort_pre_sel", {24'd0, rd_sel}, 32'h08);
        #2 rst = 1'b1;
        #1;
        chk("abort_async_sel", {16'd0, rd_sel, wr_sel}, 32'd0);
        chk("abort_async_sys", sys.wdata, 32'd0);
        chk("abort_async_out", {31'd0, ready | err}, 32'd0);
        @(negedge clk);
        chk("abort_no_ready", {31'd0, ready}, 32'd0);
        rst = 1'b0; req = 1'b1; we = 1'b1; addr = 5'b001_11; wdata = 32'hCAFEF00D;
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
        chk("post_rst_wr_sel", {24'd0, wr_sel}, 32'h02);
        chk("post_rst_wdata", sys.wdata, 32'hCAFEF00D);
        chk("post_rst_waddr", {30'd0, sys.waddr}, 32'd3);
        sp_ack = 8'h02;
        @(negedge clk);
        sp_ack = 8'd0;
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        chk("post_rst_err", {31'd0, err}, 32'd0);

        // Back-to-back requests with ack tied high: one completion every 3 cycles.
        @(negedge clk);
        sp_ack = 8'hFF; req = 1'b1; we = 1'b0; addr = 5'b100_00;
        rdy_seen = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_%0d", i), {31'd0, ready}, {31'd0, (i % 3) == 2});
            if (ready) begin
                rdy_seen++;
                chk("b2b_rdata", rdata, 32'hC0DE0004);
            end
        end
        chk("b2b_count", rdy_seen, 32'd4);
        req = 1'b0; sp_ack = 8'd0;
        @(negedge clk); @(negedge clk); @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
